// File: rtl/mult_resp_pipe.sv
// +--------------------------------------------------------------------------+
// | mult_resp_pipe : limb-serial pipelined a*b multiplier, credit-based FIFO  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module mult_resp_pipe #(
  parameter int DAT_BITS   = 256,
  parameter int CTL_BITS   = 8,
  parameter int LIMB_BITS  = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  // request stream: a = dat[0 +: DAT_BITS], b = dat[DAT_BITS +: DAT_BITS]
  input  logic                  i_req_val,
  input  logic [2*DAT_BITS-1:0] i_req_dat,
  input  logic [CTL_BITS-1:0]   i_req_ctl,
  input  logic                  i_req_sop,
  input  logic                  i_req_eop,
  output logic                  i_req_rdy,
  // product stream
  output logic                  o_res_val,
  output logic [2*DAT_BITS-1:0] o_res_dat,
  output logic [CTL_BITS-1:0]   o_res_ctl,
  output logic                  o_res_sop,
  output logic                  o_res_eop,
  input  logic                  o_res_rdy,
  output logic                  o_err
);

  localparam int NUM_LIMBS = (DAT_BITS + LIMB_BITS - 1) / LIMB_BITS;
  localparam int L         = NUM_LIMBS + 2;
  localparam int ACC_W     = 2 * DAT_BITS;
  localparam int A_W       = NUM_LIMBS * LIMB_BITS;
  localparam int PP_W      = LIMB_BITS + DAT_BITS;
  localparam int ENT_W     = ACC_W + CTL_BITS;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < L) begin : g_depth_chk
    $error("mult_resp_pipe: FIFO_DEPTH must be >= NUM_LIMBS+2");
  end

  logic             w_accept;
  logic             w_pop;
  logic             w_wr;
  logic             w_wr_ok;
  logic             w_full;
  logic             w_empty;

  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] fcnt_q,   fcnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             err_q,    err_d;

  // Stage j holds a shifted right by j limbs, so its low limb feeds stage j+1.
  logic [NUM_LIMBS:0]    val_q;
  logic [A_W-1:0]        a_q   [NUM_LIMBS];
  logic [DAT_BITS-1:0]   b_q   [NUM_LIMBS];
  logic [CTL_BITS-1:0]   ctl_q [NUM_LIMBS+1];
  logic [ACC_W-1:0]      acc_q [1:NUM_LIMBS];
  logic [ACC_W-1:0]      w_pp_sh [1:NUM_LIMBS];

  logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];

  assign w_accept  = i_req_val && i_req_rdy;
  assign i_req_rdy = (cnt_q < CNT_W'(FIFO_DEPTH));

  for (genvar j = 1; j <= NUM_LIMBS; j++) begin : g_pp
    logic [PP_W-1:0] w_pp;
    assign w_pp       = PP_W'(a_q[j-1][LIMB_BITS-1:0]) * PP_W'(b_q[j-1]);
    assign w_pp_sh[j] = ACC_W'(w_pp) << ((j - 1) * LIMB_BITS);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      val_q <= '0;
    end else begin
      val_q <= {val_q[NUM_LIMBS-1:0], w_accept};
    end
    a_q[0]   <= A_W'(i_req_dat[0 +: DAT_BITS]);
    b_q[0]   <= i_req_dat[DAT_BITS +: DAT_BITS];
    ctl_q[0] <= i_req_ctl;
    for (int j = 1; j <= NUM_LIMBS; j++) begin
      ctl_q[j] <= ctl_q[j-1];
    end
    for (int j = 1; j < NUM_LIMBS; j++) begin
      a_q[j] <= a_q[j-1] >> LIMB_BITS;
      b_q[j] <= b_q[j-1];
    end
    acc_q[1] <= w_pp_sh[1];
    for (int j = 2; j <= NUM_LIMBS; j++) begin
      acc_q[j] <= acc_q[j-1] + w_pp_sh[j];
    end
  end

  // Output FIFO: show-ahead, no write-to-read bypass.
  assign w_empty = (fcnt_q == '0);
  assign w_full  = (fcnt_q == CNT_W'(FIFO_DEPTH));
  assign w_pop   = !w_empty && o_res_rdy;
  assign w_wr    = val_q[NUM_LIMBS];
  assign w_wr_ok = w_wr && !w_full;

  always_comb begin
    cnt_d    = cnt_q + CNT_W'(w_accept) - CNT_W'(w_pop);
    fcnt_d   = fcnt_q + CNT_W'(w_wr_ok) - CNT_W'(w_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_wr_ok) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    err_d = err_q
          | (w_accept && !(i_req_sop && i_req_eop))
          | (w_wr && w_full);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q    <= '0;
      fcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
    if (w_wr_ok) begin
      mem_q[wr_ptr_q] <= {acc_q[NUM_LIMBS], ctl_q[NUM_LIMBS]};
    end
  end

  assign {o_res_dat, o_res_ctl} = mem_q[rd_ptr_q];
  assign o_res_val = !w_empty;
  assign o_res_sop = o_res_val;
  assign o_res_eop = o_res_val;
  assign o_err     = err_q;

  a_no_fifo_overflow : assert property (@(posedge i_clk) disable iff (i_rst) !(w_wr && w_full));

endmodule

`default_nettype wire

// File: tb/tb_mult_resp_pipe.sv
// +--------------------------------------------------------------------------+
// | tb_mult_resp_pipe : directed self-checking bench for mult_resp_pipe       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_mult_resp_pipe;

  localparam int DAT_BITS   = 16;
  localparam int CTL_BITS   = 8;
  localparam int LIMB_BITS  = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int L          = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_req_val;
  logic [2*DAT_BITS-1:0] i_req_dat;
  logic [CTL_BITS-1:0]   i_req_ctl;
  logic                  i_req_sop;
  logic                  i_req_eop;
  logic                  i_req_rdy;
  logic                  o_res_val;
  logic [2*DAT_BITS-1:0] o_res_dat;
  logic [CTL_BITS-1:0]   o_res_ctl;
  logic                  o_res_sop;
  logic                  o_res_eop;
  logic                  o_res_rdy;
  logic                  o_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_spur   = 0;
  logic [39:0] exp_q [$];
  int          pop_cyc_q [$];
  logic [39:0] mon_ent;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mult_resp_pipe #(
    .DAT_BITS  (DAT_BITS),
    .CTL_BITS  (CTL_BITS),
    .LIMB_BITS (LIMB_BITS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req_val(i_req_val),
    .i_req_dat(i_req_dat),
    .i_req_ctl(i_req_ctl),
    .i_req_sop(i_req_sop),
    .i_req_eop(i_req_eop),
    .i_req_rdy(i_req_rdy),
    .o_res_val(o_res_val),
    .o_res_dat(o_res_dat),
    .o_res_ctl(o_res_ctl),
    .o_res_sop(o_res_sop),
    .o_res_eop(o_res_eop),
    .o_res_rdy(o_res_rdy),
    .o_err    (o_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: a pop happens at the next rising edge when val && rdy.
  always @(negedge clk) begin
    if (!rst && o_res_val && o_res_rdy) begin
      if (exp_q.size() == 0) begin
        n_spur++;
        check("unexpected_product", 1, 0);
      end else begin
        mon_ent = exp_q.pop_front();
        check("res_dat", o_res_dat, mon_ent[39:8]);
        check("res_ctl", o_res_ctl, mon_ent[7:0]);
        check("res_sop_eop", {o_res_sop, o_res_eop}, 2'b11);
        pop_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic drive_idx(input int idx);
    logic [15:0] a;
    logic [15:0] b;
    a = 16'(idx);
    b = 16'(idx + 1);
    i_req_val = 1'b1;
    i_req_dat = {b, a};
    i_req_ctl = 8'(idx);
    i_req_sop = 1'b1;
    i_req_eop = 1'b1;
  endtask

  task automatic push_idx(input int idx);
    logic [31:0] p;
    p = 32'(idx) * 32'(idx + 1);
    exp_q.push_back({p, 8'(idx)});
  endtask

  task automatic run_stream(input int first, input int n, input int budget,
                            output int accepted, output int stalls);
    logic r;
    accepted = 0;
    stalls   = 0;
    for (int c = 0; c < budget && accepted < n; c++) begin
      drive_idx(first + accepted);
      @(negedge clk);
      r = i_req_rdy;
      @(posedge clk);
      #1;
      if (r) begin
        push_idx(first + accepted);
        accepted++;
      end else begin
        stalls++;
      end
    end
    i_req_val = 1'b0;
  endtask

  task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic [7:0] ctl,
                          input logic sop, input logic eop, input logic [31:0] exp);
    logic r;
    r = 1'b0;
    i_req_val = 1'b1;
    i_req_dat = {b, a};
    i_req_ctl = ctl;
    i_req_sop = sop;
    i_req_eop = eop;
    for (int c = 0; c < 20 && !r; c++) begin
      @(negedge clk);
      r = i_req_rdy;
      @(posedge clk);
      #1;
    end
    i_req_val = 1'b0;
    i_req_sop = 1'b1;
    i_req_eop = 1'b1;
    if (r) exp_q.push_back({exp, ctl});
    else   check("send_timeout", 0, 1);
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   acc;
    int   st;
    int   lat;
    int   spur0;
    logic r;

    rst       = 1'b1;
    i_req_val = 1'b0;
    i_req_dat = '0;
    i_req_ctl = '0;
    i_req_sop = 1'b1;
    i_req_eop = 1'b1;
    o_res_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_rdy", i_req_rdy, 1);
    check("reset_val", o_res_val, 0);
    check("reset_err", o_err, 0);

    // Single beat, latency L
    send_one(16'h0003, 16'h0005, 8'h5A, 1'b1, 1'b1, 32'h0000_000F);
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (o_res_val) begin
        lat = c;
        break;
      end
    end
    check("single_latency", lat, L);
    check("single_err", o_err, 0);
    drain(10);

    // Operand extremes
    send_one(16'hFFFF, 16'hFFFF, 8'h11, 1'b1, 1'b1, 32'hFFFE_0001);
    send_one(16'hFFFF, 16'h0000, 8'h22, 1'b1, 1'b1, 32'h0000_0000);
    drain(20);

    // Back-to-back stream
    pop_cyc_q.delete();
    run_stream(1, 20, 20, acc, st);
    check("b2b_accepted", acc, 20);
    check("b2b_stalls", st, 0);
    drain(20);
    check("b2b_count", pop_cyc_q.size(), 20);
    if (pop_cyc_q.size() == 20) check("b2b_gapless", pop_cyc_q[19] - pop_cyc_q[0], 19);

    // Backpressure: exactly FIFO_DEPTH credits
    o_res_rdy = 1'b0;
    run_stream(100, 12, 16, acc, st);
    check("bp_accepted", acc, FIFO_DEPTH);
    check("bp_rdy_low", i_req_rdy, 0);
    check("bp_val", o_res_val, 1);
    check("bp_head_dat", o_res_dat, 32'd10100);
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_dat", o_res_dat, 32'd10100);
    check("bp_hold_ctl", o_res_ctl, 8'd100);
    check("bp_hold_val", o_res_val, 1);
    o_res_rdy = 1'b1;
    @(negedge clk);
    check("bp_rdy_before_pop", i_req_rdy, 0);
    @(posedge clk);
    #1;
    check("bp_rdy_after_pop", i_req_rdy, 1);
    run_stream(108, 4, 30, acc, st);
    check("bp_rest_accepted", acc, 4);
    drain(40);
    check("bp_err", o_err, 0);

    // Credit boundary at cnt = FIFO_DEPTH-1
    o_res_rdy = 1'b0;
    run_stream(200, 7, 10, acc, st);
    check("bnd_accepted", acc, 7);
    repeat (6) @(posedge clk);
    #1;
    o_res_rdy = 1'b1;
    drive_idx(207);
    @(negedge clk);
    r = i_req_rdy;
    check("bnd_rdy_at7", r, 1);
    @(posedge clk);
    #1;
    if (r) push_idx(207);
    o_res_rdy = 1'b0;
    check("bnd_rdy_hold", i_req_rdy, 1);
    drive_idx(208);
    @(negedge clk);
    r = i_req_rdy;
    check("bnd_accept_last", r, 1);
    @(posedge clk);
    #1;
    if (r) push_idx(208);
    i_req_val = 1'b0;
    check("bnd_rdy_full", i_req_rdy, 0);
    o_res_rdy = 1'b1;
    drain(40);

    // Framing error is sticky, beat still processed
    send_one(16'h0007, 16'h0009, 8'h3C, 1'b0, 1'b1, 32'd63);
    check("err_set", o_err, 1);
    drain(20);
    check("err_sticky", o_err, 1);

    // Reset with beats in flight
    run_stream(300, 3, 3, acc, st);
    check("rst_inflight_accepted", acc, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("post_rst_val", o_res_val, 0);
    check("post_rst_rdy", i_req_rdy, 1);
    check("post_rst_err", o_err, 0);
    spur0 = n_spur;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_no_output", n_spur - spur0, 0);
    check("post_rst_idle_val", o_res_val, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
